// File: rtl/vect_lane_serializer.sv
// vect_lane_serializer: buffers packed M-lane vectors from the vector ALU in a small FIFO and
// emits them one signed lane per cycle (lane 0 first) on a valid/ready scalar stream.
// Optional feature: define VECT_SERIALIZER_STICKY_FLAGS_EN to accumulate pushed ALU flags
// into sticky_flags (cleared by sticky_clr); otherwise sticky_flags is constant 0.
module vect_lane_serializer #(
  parameter int unsigned N     = 8,
  parameter int unsigned M     = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [M*N-1:0]       in_vec,
  input  logic [3:0]           in_flags,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic [$clog2(M)-1:0] out_lane,
  output logic                 out_last,
  output logic [3:0]           out_flags,
  output logic [3:0]           sticky_flags,
  input  logic                 sticky_clr,
  output logic                 busy
);

  localparam int unsigned LaneW = $clog2(M);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {StEmpty, StStream} state_e;

  logic [M*N-1:0]   vec_mem  [DEPTH];
  logic [3:0]       flag_mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [LaneW-1:0] lane_cnt_q;
  state_e           state_q, state_d;

  logic             push, lane_xfer, pop;
  logic [M*N-1:0]   head_vec;

  assign in_ready  = (count_q != CntW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign lane_xfer = out_valid && out_ready;
  // The head vector leaves the FIFO only once its last lane has been accepted.
  assign pop       = lane_xfer && (lane_cnt_q == LaneW'(M - 1));
  assign head_vec  = vec_mem[rd_ptr_q];

  // Vector storage; no reset needed since reads are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      vec_mem[wr_ptr_q]  <= in_vec;
      flag_mem[wr_ptr_q] <= in_flags;
    end
  end

  // FIFO pointers, occupancy and lane position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lane_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (lane_xfer) lane_cnt_q <= pop ? '0 : lane_cnt_q + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StEmpty;
    else        state_q <= state_d;
  end

  // Next state and lane output mux; all outputs are zero while nothing is stored.
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_data  = '0;
    out_lane  = '0;
    out_last  = 1'b0;
    out_flags = '0;
    unique case (state_q)
      StEmpty: begin
        if (push) state_d = StStream;
      end
      StStream: begin
        if (pop && !push && (count_q == CntW'(1))) state_d = StEmpty;
        out_valid = 1'b1;
        out_lane  = lane_cnt_q;
        out_last  = (lane_cnt_q == LaneW'(M - 1));
        out_flags = flag_mem[rd_ptr_q];
        // Lane 0 sits in the most significant slice of the packed vector.
        for (int i = 0; i < int'(M); i++) begin
          if (lane_cnt_q == LaneW'(i)) out_data = head_vec[(int'(M) - 1 - i) * int'(N) +: N];
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  assign busy = out_valid;

`ifdef VECT_SERIALIZER_STICKY_FLAGS_EN
  logic [3:0] sticky_q;

  // Sticky flag accumulator; a clear coinciding with a push keeps only the new flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else if (push) begin
      sticky_q <= (sticky_clr ? 4'h0 : sticky_q) | in_flags;
    end else if (sticky_clr) begin
      sticky_q <= '0;
    end
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_sticky_clr;

  assign unused_sticky_clr = sticky_clr;
  assign sticky_flags      = '0;
`endif

endmodule
